// File: rtl/riscv_core_icache_nway_memory_if.sv
// Fetch, refill and flush signals shared between the instruction cache and
// its core/refill master. The cache takes the slave side.
interface riscv_core_icache_nway_memory_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int AXI_DATA_WIDTH = 64
);
  // Refill beats transfer on every cycle where i_beat_valid and o_beat_ready are
  // both 1; the master keeps i_beat_data stable while i_beat_valid is 1.
  logic                      i_rd_en;
  logic [ADDR_WIDTH-1:0]     i_addr_from_core;
  logic [31:0]               o_data_to_core;
  logic                      o_hit;
  logic [ADDR_WIDTH-1:0]     o_miss_addr;
  logic                      i_refill_start;
  logic [ADDR_WIDTH-1:0]     i_refill_addr;
  logic                      i_beat_valid;
  logic                      o_beat_ready;
  logic [AXI_DATA_WIDTH-1:0] i_beat_data;
  logic                      o_refill_done;
  logic                      i_flush;
  logic                      o_busy;
  logic [1:0]                dbg_state;

  modport slave (
    input  i_rd_en, i_addr_from_core, i_refill_start, i_refill_addr,
           i_beat_valid, i_beat_data, i_flush,
    output o_data_to_core, o_hit, o_miss_addr, o_beat_ready, o_refill_done,
           o_busy, dbg_state
  );

  modport master (
    output i_rd_en, i_addr_from_core, i_refill_start, i_refill_addr,
           i_beat_valid, i_beat_data, i_flush,
    input  o_data_to_core, o_hit, o_miss_addr, o_beat_ready, o_refill_done,
           o_busy, dbg_state
  );
endinterface

// File: rtl/riscv_core_icache_nway_memory.sv
// N-way set-associative instruction cache storage with combinational lookup,
// line-crossing fetch support, beat-wise refill and a set-by-set fence.i flush.
module riscv_core_icache_nway_memory #(
  parameter int NUM_WAYS           = 2,
  parameter int INDEX_WIDTH        = 7,
  parameter int BLOCK_OFFSET_WIDTH = 3,
  parameter int ADDR_WIDTH         = 32,
  parameter int AXI_DATA_WIDTH     = 64
) (
  input logic                           i_clk,
  input logic                           i_rst_n,
  riscv_core_icache_nway_memory_if.slave bus
);
  localparam int CACHE_DEPTH = 2 ** INDEX_WIDTH;
  localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - BLOCK_OFFSET_WIDTH - 2;
  localparam int LINE_WIDTH  = 32 * (2 ** BLOCK_OFFSET_WIDTH);
  localparam int BEATS       = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int WAY_W       = $clog2(NUM_WAYS);
  localparam int BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LINE_AW     = ADDR_WIDTH - BLOCK_OFFSET_WIDTH - 2;
  localparam int OFF_W       = BLOCK_OFFSET_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, FILL, COMMIT, FLUSH} state_t;

  // Storage
  logic [TAG_WIDTH-1:0]      tag_mem  [NUM_WAYS][CACHE_DEPTH];
  logic [LINE_WIDTH-1:0]     data_mem [NUM_WAYS][CACHE_DEPTH];
  logic [CACHE_DEPTH-1:0]    valid_q  [NUM_WAYS];
  logic [WAY_W-1:0]          rr_q     [CACHE_DEPTH];
  logic [AXI_DATA_WIDTH-1:0] line_buf [BEATS];

  // Control state
  state_t                 state;
  logic [BEAT_W-1:0]      beat_cnt;
  logic                   flush_pend;
  logic [INDEX_WIDTH-1:0] flush_idx;
  logic [LINE_AW-1:0]     refill_line;
  logic [WAY_W-1:0]       victim;
  logic                   victim_rr;

  // Address decomposition for the two fetch halfwords and the refill probe
  logic [ADDR_WIDTH-1:0]         addr_lo;
  logic [ADDR_WIDTH-1:0]         addr_hi;
  logic [LINE_AW-1:0]            line_lo;
  logic [LINE_AW-1:0]            line_hi;
  logic [LINE_AW-1:0]            line_rf;
  logic [BLOCK_OFFSET_WIDTH:0]   hw_lo;
  logic [BLOCK_OFFSET_WIDTH:0]   hw_hi;
  logic [INDEX_WIDTH-1:0]        idx_lo;
  logic [INDEX_WIDTH-1:0]        idx_hi;
  logic [INDEX_WIDTH-1:0]        idx_rf;
  logic [TAG_WIDTH-1:0]          tag_lo;
  logic [TAG_WIDTH-1:0]          tag_hi;
  logic [TAG_WIDTH-1:0]          tag_rf;
  logic [INDEX_WIDTH-1:0]        refill_idx;
  logic [TAG_WIDTH-1:0]          refill_tag;

  assign addr_lo    = {bus.i_addr_from_core[ADDR_WIDTH-1:1], 1'b0};
  assign addr_hi    = addr_lo + ADDR_WIDTH'(2);
  assign line_lo    = addr_lo[ADDR_WIDTH-1:OFF_W];
  assign line_hi    = addr_hi[ADDR_WIDTH-1:OFF_W];
  assign line_rf    = bus.i_refill_addr[ADDR_WIDTH-1:OFF_W];
  assign hw_lo      = addr_lo[OFF_W-1:1];
  assign hw_hi      = addr_hi[OFF_W-1:1];
  assign idx_lo     = line_lo[INDEX_WIDTH-1:0];
  assign idx_hi     = line_hi[INDEX_WIDTH-1:0];
  assign idx_rf     = line_rf[INDEX_WIDTH-1:0];
  assign tag_lo     = line_lo[LINE_AW-1:INDEX_WIDTH];
  assign tag_hi     = line_hi[LINE_AW-1:INDEX_WIDTH];
  assign tag_rf     = line_rf[LINE_AW-1:INDEX_WIDTH];
  assign refill_idx = refill_line[INDEX_WIDTH-1:0];
  assign refill_tag = refill_line[LINE_AW-1:INDEX_WIDTH];

  // Tag match for both fetch lines and the refill line. At most one way can
  // match per line, so OR-ing the matching rows yields the selected line.
  logic                  hit_lo;
  logic                  hit_hi;
  logic                  hit_rf;
  logic [WAY_W-1:0]      way_rf;
  logic [LINE_WIDTH-1:0] row_lo;
  logic [LINE_WIDTH-1:0] row_hi;

  always_comb begin
    hit_lo = 1'b0;
    hit_hi = 1'b0;
    hit_rf = 1'b0;
    way_rf = '0;
    row_lo = '0;
    row_hi = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[w][idx_lo] && (tag_mem[w][idx_lo] == tag_lo)) begin
        hit_lo = 1'b1;
        row_lo = row_lo | data_mem[w][idx_lo];
      end
      if (valid_q[w][idx_hi] && (tag_mem[w][idx_hi] == tag_hi)) begin
        hit_hi = 1'b1;
        row_hi = row_hi | data_mem[w][idx_hi];
      end
      if (valid_q[w][idx_rf] && (tag_mem[w][idx_rf] == tag_rf)) begin
        hit_rf = 1'b1;
        way_rf = WAY_W'(w);
      end
    end
  end

  // A non-crossing fetch resolves both halves to the same line, so the
  // two-line hit rule covers both cases.
  logic [15:0]           half_lo;
  logic [15:0]           half_hi;
  logic                  hit_out;
  logic [ADDR_WIDTH-1:0] miss_addr;

  assign half_lo = row_lo[{hw_lo, 4'b0000} +: 16];
  assign half_hi = row_hi[{hw_hi, 4'b0000} +: 16];
  assign hit_out = bus.i_rd_en && (state == IDLE) && hit_lo && hit_hi;

  always_comb begin
    miss_addr = '0;
    if (!i_rst_n) begin
      miss_addr = '0;
    end else if (!hit_lo) begin
      miss_addr = {line_lo, {OFF_W{1'b0}}};
    end else if (!hit_hi) begin
      miss_addr = {line_hi, {OFF_W{1'b0}}};
    end
  end

  assign bus.o_hit          = hit_out;
  assign bus.o_data_to_core = hit_out ? {half_hi, half_lo} : 32'd0;
  assign bus.o_miss_addr    = miss_addr;
  assign bus.o_beat_ready   = (state == FILL);
  assign bus.o_refill_done  = (state == COMMIT);
  assign bus.o_busy         = (state != IDLE);
  assign bus.dbg_state      = state;

  // Victim choice: the line's own way if already resident, else the lowest
  // invalid way, else the set's round-robin pointer.
  logic [WAY_W-1:0] victim_next;
  logic             victim_from_rr;

  always_comb begin
    victim_next    = rr_q[idx_rf];
    victim_from_rr = 1'b1;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][idx_rf]) begin
        victim_next    = WAY_W'(w);
        victim_from_rr = 1'b0;
      end
    end
    if (hit_rf) begin
      victim_next    = way_rf;
      victim_from_rr = 1'b0;
    end
  end

  logic [LINE_WIDTH-1:0] line_flat;

  always_comb begin
    line_flat = '0;
    for (int b = 0; b < BEATS; b++) begin
      line_flat[b*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = line_buf[b];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      flush_pend  <= 1'b0;
      flush_idx   <= '0;
      refill_line <= '0;
      victim      <= '0;
      victim_rr   <= 1'b0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        valid_q[w] <= '0;
      end
      for (int s = 0; s < CACHE_DEPTH; s++) begin
        rr_q[s] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_flush) begin
            state     <= FLUSH;
            flush_idx <= '0;
          end else if (bus.i_refill_start) begin
            state       <= FILL;
            refill_line <= line_rf;
            victim      <= victim_next;
            victim_rr   <= victim_from_rr;
            beat_cnt    <= '0;
          end
        end
        FILL: begin
          if (bus.i_flush) begin
            flush_pend <= 1'b1;
          end
          if (bus.i_beat_valid) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
            if (beat_cnt == BEAT_W'(BEATS - 1)) begin
              state    <= COMMIT;
              beat_cnt <= '0;
            end
          end
        end
        COMMIT: begin
          valid_q[victim][refill_idx] <= 1'b1;
          if (victim_rr) begin
            rr_q[refill_idx] <= victim + WAY_W'(1);
          end
          flush_pend <= 1'b0;
          flush_idx  <= '0;
          state      <= (flush_pend || bus.i_flush) ? FLUSH : IDLE;
        end
        FLUSH: begin
          for (int w = 0; w < NUM_WAYS; w++) begin
            valid_q[w][flush_idx] <= 1'b0;
          end
          rr_q[flush_idx] <= '0;
          flush_idx       <= flush_idx + INDEX_WIDTH'(1);
          if (flush_idx == {INDEX_WIDTH{1'b1}}) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Unreset storage; an asynchronous reset in FILL leaves state at IDLE, so
  // the abandoned line never reaches the arrays.
  always_ff @(posedge i_clk) begin
    if ((state == FILL) && bus.i_beat_valid) begin
      line_buf[beat_cnt] <= bus.i_beat_data;
    end
    if (state == COMMIT) begin
      tag_mem[victim][refill_idx]  <= refill_tag;
      data_mem[victim][refill_idx] <= line_flat;
    end
  end
endmodule

// File: tb/tb_riscv_core_icache_nway_memory.sv
// Bench for the instruction cache: directed vector table, hand-written refill,
// flush and reset sequences, then randomized traffic against a cache model.
module tb_riscv_core_icache_nway_memory;
  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int BEATS = 4;
  localparam int SETS  = 128;
  localparam int WAYS  = 2;

  // Clock and reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_core_icache_nway_memory_if #(.ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) bus ();

  riscv_core_icache_nway_memory dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference cache contents: which line occupies which way of each set
  logic [19:0] m_tag   [SETS][WAYS];
  bit          m_valid [SETS][WAYS];
  int          m_rr    [SETS];

  // Backing memory: the word at byte address a holds (a - 0x1000) / 4
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a - 32'h0000_1000) >> 2;
  endfunction

  function automatic logic [15:0] mem_half(input logic [31:0] b);
    logic [31:0] w;
    w = mem_word({b[31:2], 2'b00});
    return b[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic int model_way(input logic [31:0] line);
    int s;
    s = int'(line[11:5]);
    model_way = -1;
    for (int w = 0; w < WAYS; w++) begin
      if (m_valid[s][w] && (m_tag[s][w] == line[31:12])) model_way = w;
    end
  endfunction

  function automatic void model_fetch(input logic [31:0] addr, input logic rd_en,
                                      output logic [64:0] res);
    logic [31:0] a, b, lo, hi, miss, data;
    bit p_lo, p_hi, hit;
    a    = {addr[31:1], 1'b0};
    b    = a + 32'd2;
    lo   = {a[31:5], 5'b0};
    hi   = {b[31:5], 5'b0};
    p_lo = (model_way(lo) >= 0);
    p_hi = (model_way(hi) >= 0);
    hit  = rd_en && p_lo && p_hi;
    data = hit ? {mem_half(b), mem_half(a)} : 32'd0;
    miss = !p_lo ? lo : (!p_hi ? hi : 32'd0);
    res  = {hit, data, miss};
  endfunction

  function automatic void model_pick(input logic [31:0] line, output int way,
                                     output bit from_rr);
    int s;
    s       = int'(line[11:5]);
    from_rr = 1'b0;
    way     = model_way(line);
    if (way < 0) begin
      for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) way = w;
    end
    if (way < 0) begin
      way     = m_rr[s];
      from_rr = 1'b1;
    end
  endfunction

  function automatic void model_commit(input logic [31:0] line, input int way,
                                       input bit from_rr);
    int s;
    s = int'(line[11:5]);
    m_valid[s][way] = 1'b1;
    m_tag[s][way]   = line[31:12];
    if (from_rr) m_rr[s] = (m_rr[s] + 1) % WAYS;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endfunction

  // Scoreboard: expected {hit, data, miss_addr} per lookup
  logic [64:0] exp_q[$];

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_lookup(input string name);
    logic [64:0] exp, act;
    exp = exp_q.pop_front();
    act = {bus.o_hit, bus.o_data_to_core, bus.o_miss_addr};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s addr=%h: got hit=%0b data=%h miss=%h expected hit=%0b data=%h miss=%h",
               name, bus.i_addr_from_core, act[64], act[63:32], act[31:0],
               exp[64], exp[63:32], exp[31:0]);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge,
  // outputs are sampled on the falling edge.
  task automatic drive_addr(input logic [31:0] addr, input logic rd_en);
    @(posedge clk);
    #1;
    bus.i_addr_from_core = addr;
    bus.i_rd_en          = rd_en;
  endtask

  task automatic lookup_model(input logic [31:0] addr, input logic rd_en, input string name);
    logic [64:0] e;
    drive_addr(addr, rd_en);
    model_fetch(addr, rd_en, e);
    exp_q.push_back(e);
    @(negedge clk);
    check_lookup(name);
  endtask

  task automatic refill(input logic [31:0] addr, input int flush_beat,
                        input int reset_beat, input int max_gap);
    logic [31:0] line;
    int way, gap;
    bit from_rr;
    line = {addr[31:5], 5'b0};
    @(posedge clk);
    #1;
    model_pick(line, way, from_rr);
    bus.i_refill_start = 1'b1;
    bus.i_refill_addr  = addr;
    @(posedge clk);
    #1;
    bus.i_refill_start = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      gap = $urandom_range(max_gap, 0);
      for (int g = 0; g < gap; g++) begin
        bus.i_beat_valid   = 1'b0;
        bus.i_beat_data    = {$urandom, $urandom};
        bus.i_refill_start = ($urandom_range(1, 0) == 1);
        bus.i_refill_addr  = $urandom;
        @(negedge clk);
        check_val("fill_ready_gap", 64'(bus.o_beat_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.i_refill_start = 1'b0;
      end
      bus.i_beat_valid = 1'b1;
      bus.i_beat_data  = {mem_word(line + 32'(8 * b) + 32'd4), mem_word(line + 32'(8 * b))};
      bus.i_flush      = (b == flush_beat);
      @(negedge clk);
      check_val("fill_ready", 64'(bus.o_beat_ready), 64'd1);
      check_val("fill_busy", 64'(bus.o_busy), 64'd1);
      @(posedge clk);
      #1;
      bus.i_beat_valid = 1'b0;
      bus.i_flush      = 1'b0;
      if (b == reset_beat) begin
        rst_n = 1'b0;
        #1;
        check_val("rst_fill_busy", 64'(bus.o_busy), 64'd0);
        check_val("rst_fill_ready", 64'(bus.o_beat_ready), 64'd0);
        check_val("rst_fill_done", 64'(bus.o_refill_done), 64'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    @(negedge clk);
    check_val("commit_done", 64'(bus.o_refill_done), 64'd1);
    check_val("commit_ready", 64'(bus.o_beat_ready), 64'd0);
    model_commit(line, way, from_rr);
    @(negedge clk);
    check_val("done_pulse_end", 64'(bus.o_refill_done), 64'd0);
  endtask

  // Counts FLUSH cycles from the current falling edge; re-asserts i_flush
  // mid-flush, which must not restart it.
  task automatic wait_flush(input string name);
    int cnt;
    cnt = 0;
    while ((bus.o_busy === 1'b1) && (cnt < 300)) begin
      bus.i_flush = (cnt == 5);
      cnt++;
      @(negedge clk);
    end
    bus.i_flush = 1'b0;
    check_val(name, 64'(cnt), 64'd128);
    model_clear();
  endtask

  // Directed vector table
  typedef struct {
    int          phase;
    logic [31:0] addr;
    logic        rd_en;
    logic        exp_hit;
    logic [31:0] exp_data;
    logic [31:0] exp_miss;
  } vec_t;

  vec_t vecs[14];

  task automatic run_phase(input int p);
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].phase == p) begin
        drive_addr(vecs[i].addr, vecs[i].rd_en);
        exp_q.push_back({vecs[i].exp_hit, vecs[i].exp_data, vecs[i].exp_miss});
        @(negedge clk);
        check_lookup($sformatf("vec%0d", i));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int r;
    vecs[0]  = '{0, 32'h0000_1000, 1'b1, 1'b0, 32'h0,          32'h0000_1000};
    vecs[1]  = '{1, 32'h0000_1004, 1'b1, 1'b1, 32'h0000_0001, 32'h0};
    vecs[2]  = '{1, 32'h0000_1002, 1'b1, 1'b1, 32'h0001_0000, 32'h0};
    vecs[3]  = '{1, 32'h0000_1005, 1'b1, 1'b1, 32'h0000_0001, 32'h0};
    vecs[4]  = '{1, 32'h0000_101E, 1'b1, 1'b0, 32'h0,          32'h0000_1020};
    vecs[5]  = '{1, 32'h0000_1004, 1'b0, 1'b0, 32'h0,          32'h0};
    vecs[6]  = '{1, 32'h0000_1006, 1'b1, 1'b1, 32'h0002_0000, 32'h0};
    vecs[7]  = '{2, 32'h0000_101E, 1'b1, 1'b1, 32'h0008_0000, 32'h0};
    vecs[8]  = '{2, 32'h0000_103E, 1'b1, 1'b0, 32'h0,          32'h0000_1040};
    vecs[9]  = '{2, 32'h0000_0FFE, 1'b1, 1'b0, 32'h0,          32'h0000_0FE0};
    vecs[10] = '{3, 32'h0000_1000, 1'b1, 1'b0, 32'h0,          32'h0000_1000};
    vecs[11] = '{3, 32'h0000_2000, 1'b1, 1'b1, 32'h0000_0400, 32'h0};
    vecs[12] = '{3, 32'h0000_3008, 1'b1, 1'b1, 32'h0000_0802, 32'h0};
    vecs[13] = '{3, 32'h0000_1020, 1'b1, 1'b1, 32'h0000_0008, 32'h0};

    bus.i_rd_en          = 1'b1;
    bus.i_addr_from_core = 32'h0000_1000;
    bus.i_refill_start   = 1'b0;
    bus.i_refill_addr    = '0;
    bus.i_beat_valid     = 1'b1;
    bus.i_beat_data      = 64'hDEAD_BEEF_0BAD_F00D;
    bus.i_flush          = 1'b0;
    model_clear();

    // Outputs while reset is held
    repeat (3) @(negedge clk);
    check_val("rst_hit", 64'(bus.o_hit), 64'd0);
    check_val("rst_data", 64'(bus.o_data_to_core), 64'd0);
    check_val("rst_miss", 64'(bus.o_miss_addr), 64'd0);
    check_val("rst_ready", 64'(bus.o_beat_ready), 64'd0);
    check_val("rst_done", 64'(bus.o_refill_done), 64'd0);
    check_val("rst_busy", 64'(bus.o_busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("idle_beat_ignored_ready", 64'(bus.o_beat_ready), 64'd0);
    check_val("idle_beat_ignored_busy", 64'(bus.o_busy), 64'd0);
    bus.i_beat_valid = 1'b0;

    run_phase(0);
    refill(32'h0000_1000, -1, -1, 0);
    run_phase(1);
    refill(32'h0000_1020, -1, -1, 2);
    run_phase(2);
    refill(32'h0000_2000, -1, -1, 1);
    refill(32'h0000_3000, -1, -1, 1);
    run_phase(3);

    // Refilling a resident line reuses its way; then a pointer eviction
    refill(32'h0000_2004, -1, -1, 0);
    lookup_model(32'h0000_3000, 1'b1, "resident_refill_3000");
    lookup_model(32'h0000_2000, 1'b1, "resident_refill_2000");
    refill(32'h0000_1000, -1, -1, 0);
    lookup_model(32'h0000_2000, 1'b1, "rr_evict_2000");
    lookup_model(32'h0000_3000, 1'b1, "rr_keep_3000");
    lookup_model(32'h0000_1000, 1'b1, "rr_new_1000");

    // Flush during beat 2: refill commits, then a full flush
    refill(32'h0000_4000, 2, -1, 0);
    wait_flush("flush_after_commit_len");
    lookup_model(32'h0000_4000, 1'b1, "post_flush_4000");
    lookup_model(32'h0000_3000, 1'b1, "post_flush_3000");
    lookup_model(32'h0000_1020, 1'b1, "post_flush_1020");

    // Refill start and flush together: flush wins
    @(posedge clk);
    #1;
    bus.i_refill_start = 1'b1;
    bus.i_refill_addr  = 32'h0000_5000;
    bus.i_flush        = 1'b1;
    @(posedge clk);
    #1;
    bus.i_refill_start = 1'b0;
    bus.i_flush        = 1'b0;
    @(negedge clk);
    check_val("flush_wins_ready", 64'(bus.o_beat_ready), 64'd0);
    check_val("flush_wins_busy", 64'(bus.o_busy), 64'd1);
    wait_flush("flush_wins_len");
    lookup_model(32'h0000_5000, 1'b1, "flush_wins_no_line");

    // Reset after beat 2 abandons the refill
    refill(32'h0000_1000, -1, -1, 0);
    refill(32'h0000_6000, -1, 2, 0);
    @(negedge clk);
    check_val("rst_mid_fill_busy", 64'(bus.o_busy), 64'd0);
    lookup_model(32'h0000_6000, 1'b1, "rst_mid_fill_6000");
    lookup_model(32'h0000_1000, 1'b1, "rst_mid_fill_1000");

    // Randomized traffic over four sets and five tags
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(99, 0);
      a = (32'($urandom_range(5, 1)) << 12) | (32'($urandom_range(3, 0)) << 5);
      if (r < 55) begin
        a = a | (32'($urandom_range(15, 0)) << 1) | 32'($urandom_range(1, 0));
        lookup_model(a, ($urandom_range(9, 0) != 0), "rand_lookup");
      end else if (r < 94) begin
        refill(a | 32'($urandom_range(31, 0)), -1, -1, 2);
      end else begin
        @(posedge clk);
        #1;
        bus.i_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.i_flush = 1'b0;
        @(negedge clk);
        wait_flush("rand_flush_len");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
